// File: rtl/onehot_encoder_pkg.sv
// Shared definitions for the registered 4-to-2 one-hot encoder: code constants,
// buffer state encoding and the {code, err} entry layout.
package onehot_encoder_pkg;

    localparam logic [1:0] IDX0 = 2'd0;
    localparam logic [1:0] IDX1 = 2'd1;
    localparam logic [1:0] IDX2 = 2'd2;
    localparam logic [1:0] IDX3 = 2'd3;

    localparam int ENTRY_W = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0] code;
        logic       err;
    } entry_t;

endpackage

// File: rtl/onehot_enc_core.sv
// Combinational priority encoder: 4-bit one-hot word to 2-bit index plus an
// error flag for a zero word or a word with more than one bit set.
module onehot_enc_core
    import onehot_encoder_pkg::*;
(
    input  logic [3:0] onehot,
    output logic [1:0] code,
    output logic       err
);

    // Highest set bit wins, so malformed words still map to a defined index.
    always_comb begin
        code = IDX0;
        if (onehot[3]) begin
            code = IDX3;
        end else if (onehot[2]) begin
            code = IDX2;
        end else if (onehot[1]) begin
            code = IDX1;
        end
        err = ($countones(onehot) != 1);
    end

endmodule

// File: rtl/onehot_encoder.sv
// Registered 4-to-2 one-hot encoder with a 2-entry output FIFO and valid/ready on
// both sides. Define ONEHOT_ENCODER_ERRCNT_EN to add clr_cnt/err_cnt error counting.
module onehot_encoder
    import onehot_encoder_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_onehot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_code,
    output logic             out_err
`ifdef ONEHOT_ENCODER_ERRCNT_EN
    ,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    generate
        if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
            $error("onehot_encoder: CNT_W must be within 1..16");
        end
    endgenerate

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    logic   in_ready_q, in_ready_d;
    entry_t entry_in;
    logic   accept;
    logic   drain;

    onehot_enc_core u_core (
        .onehot (in_onehot),
        .code   (entry_in.code),
        .err    (entry_in.err)
    );

    assign accept = in_valid && in_ready_q;
    assign drain  = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next-state and storage update
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    head_d  = entry_in;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    head_d = entry_in;
                end else if (accept) begin
                    state_d = TWO;
                    tail_d  = entry_in;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only a drain can move the buffer.
                if (drain) begin
                    state_d = ONE;
                    head_d  = tail_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        in_ready_d = (state_d != TWO);
    end

    // Outputs
    always_comb begin
        out_valid = (state_q != EMPTY);
        out_code  = head_q.code;
        out_err   = head_q.err;
        in_ready  = in_ready_q;
    end

`ifdef ONEHOT_ENCODER_ERRCNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Clear has priority over an increment in the same cycle.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if (accept && entry_in.err && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
